// File: rtl/corec_sleep_pkg.sv
// Shared definitions for the core-side power-gating handshake responder:
// state encodings, parameter defaults and the per-state output decode.
package corec_sleep_pkg;

    typedef enum logic [2:0] {
        ST_RUN     = 3'b000,
        ST_DRAIN   = 3'b001,
        ST_SAVE    = 3'b010,
        ST_SETTLE  = 3'b011,
        ST_SLEEP   = 3'b100,
        ST_RESTORE = 3'b101
    } pwr_state_e;

    localparam int SETTLE_CYC_DEF = 4;
    localparam int DRAIN_TMO_DEF  = 255;

    typedef struct packed {
        logic hold;
        logic save;
        logic restore;
        logic ack;
    } pwr_out_t;

    // Moore output pattern owned by each state; isolation is merged in by the top.
    function automatic pwr_out_t state_outputs(input pwr_state_e st);
        pwr_out_t o;
        o = 4'b0000;
        case (st)
            ST_RUN:     o = 4'b0000;
            ST_DRAIN:   o.hold = 1'b1;
            ST_SAVE:    begin o.hold = 1'b1; o.save = 1'b1; end
            ST_SETTLE:  o.hold = 1'b1;
            ST_SLEEP:   begin o.hold = 1'b1; o.ack = 1'b1; end
            ST_RESTORE: begin o.hold = 1'b1; o.restore = 1'b1; end
            default:    o = 4'b0000;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/corec_sleep_ctrl_if.sv
// Handshake bundle between PMU/BIU and the core sleep controller.
interface corec_sleep_ctrl_if;
    logic       pmu_corec_sleep_in;
    logic       pmu_corec_isolation;
    logic       biu_trans_req;
    logic       biu_trans_done;
    logic       corec_bus_hold;
    logic       corec_ret_save;
    logic       corec_ret_restore;
    logic       corec_pmu_sleep_out;
    logic [2:0] corec_pwr_sts;
    logic       corec_proto_err;
    logic       corec_drain_tmo;

    modport master (
        output pmu_corec_sleep_in, pmu_corec_isolation, biu_trans_req, biu_trans_done,
        input  corec_bus_hold, corec_ret_save, corec_ret_restore, corec_pmu_sleep_out,
               corec_pwr_sts, corec_proto_err, corec_drain_tmo
    );

    modport slave (
        input  pmu_corec_sleep_in, pmu_corec_isolation, biu_trans_req, biu_trans_done,
        output corec_bus_hold, corec_ret_save, corec_ret_restore, corec_pmu_sleep_out,
               corec_pwr_sts, corec_proto_err, corec_drain_tmo
    );
endinterface

// File: rtl/corec_outstd_cnt.sv
// Saturating outstanding-transaction counter; exposes the post-update count
// so the drain decision can use this cycle's req/done.
module corec_outstd_cnt #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         req_i,
    input  logic         done_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_d_o,
    output logic         err_o
);

    localparam logic [W-1:0] CNT_MAX  = {W{1'b1}};
    localparam logic [W-1:0] CNT_ZERO = {W{1'b0}};
    localparam logic [W-1:0] CNT_ONE  = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic         err_d;

    // Next count with overflow saturation and underflow suppression.
    always_comb begin
        cnt_d = cnt_q;
        err_d = 1'b0;
        if (clr_i) begin
            cnt_d = CNT_ZERO;
        end else if (req_i && !done_i) begin
            if (cnt_q == CNT_MAX) begin
                err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else if (done_i && !req_i) begin
            if (cnt_q == CNT_ZERO) begin
                err_d = 1'b1;
            end else begin
                cnt_d = cnt_q - CNT_ONE;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= CNT_ZERO;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_d_o = cnt_d;
    assign err_o   = err_d;

endmodule

// File: rtl/corec_sleep_ctrl.sv
// Core-side responder to the PMU power-gating handshake: drain, retention save,
// settle, acknowledge, restore. Optional drain watchdog: COREC_SLEEP_DRAIN_TIMEOUT_EN.
module corec_sleep_ctrl
    import corec_sleep_pkg::*;
#(
    parameter int OUTSTD_W   = 4,
    parameter int SETTLE_CYC = SETTLE_CYC_DEF,
    parameter int DRAIN_TMO  = DRAIN_TMO_DEF
) (
    input logic               pmu_clk,
    input logic               pad_cpu_rst_b,
    corec_sleep_ctrl_if.slave bus
);

    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYC - 1);

    if (SETTLE_CYC < 1 || SETTLE_CYC > 255 || DRAIN_TMO < 1 || DRAIN_TMO > 255) begin : g_param_check
        $error("corec_sleep_ctrl: SETTLE_CYC and DRAIN_TMO must lie in 1..255");
    end

    pwr_state_e          state_q;
    pwr_state_e          state_d;
    pwr_out_t            out_q;
    logic [7:0]          settle_q;
    logic                proto_err_q;
    logic [OUTSTD_W-1:0] cnt_d;
    logic                cnt_err_s;
    logic                hold_s;
    logic                tmo_fire_s;

    assign hold_s = out_q.hold | bus.pmu_corec_isolation;

    corec_outstd_cnt #(
        .W (OUTSTD_W)
    ) u_outstd_cnt (
        .clk_i   (pmu_clk),
        .rst_ni  (pad_cpu_rst_b),
        .req_i   (bus.biu_trans_req),
        .done_i  (bus.biu_trans_done),
        .clr_i   (tmo_fire_s),
        .cnt_d_o (cnt_d),
        .err_o   (cnt_err_s)
    );

`ifdef COREC_SLEEP_DRAIN_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(DRAIN_TMO - 1);

    logic [7:0] wdog_q;
    logic       drain_tmo_q;

    // An abort in the same cycle wins, so the fire requires sleep_in still high.
    assign tmo_fire_s = (state_q == ST_DRAIN) & bus.pmu_corec_sleep_in & (wdog_q == TMO_LAST);

    // Drain watchdog: held at zero outside DRAIN so every entry starts fresh.
    always_ff @(posedge pmu_clk or negedge pad_cpu_rst_b) begin
        if (!pad_cpu_rst_b) begin
            wdog_q      <= 8'd0;
            drain_tmo_q <= 1'b0;
        end else begin
            if (state_q != ST_DRAIN) begin
                wdog_q <= 8'd0;
            end else if (wdog_q != TMO_LAST) begin
                wdog_q <= wdog_q + 8'd1;
            end else begin
                wdog_q <= wdog_q;
            end
            drain_tmo_q <= drain_tmo_q | tmo_fire_s;
        end
    end

    assign bus.corec_drain_tmo = drain_tmo_q;
`else
    assign tmo_fire_s          = 1'b0;
    assign bus.corec_drain_tmo = 1'b0;
`endif

    // Next-state decision; a watchdog fire has already zeroed cnt_d.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (bus.pmu_corec_sleep_in) state_d = ST_DRAIN;
                else                        state_d = ST_RUN;
            end
            ST_DRAIN: begin
                if (!bus.pmu_corec_sleep_in)          state_d = ST_RUN;
                else if (cnt_d == {OUTSTD_W{1'b0}})   state_d = ST_SAVE;
                else                                  state_d = ST_DRAIN;
            end
            ST_SAVE: begin
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (!bus.pmu_corec_sleep_in) state_d = ST_RESTORE;
                else if (settle_q == 8'd0)   state_d = ST_SLEEP;
                else                         state_d = ST_SETTLE;
            end
            ST_SLEEP: begin
                if (!bus.pmu_corec_sleep_in) state_d = ST_RESTORE;
                else                         state_d = ST_SLEEP;
            end
            ST_RESTORE: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // State, registered outputs decoded from the next state, settle counter, sticky error.
    always_ff @(posedge pmu_clk or negedge pad_cpu_rst_b) begin
        if (!pad_cpu_rst_b) begin
            state_q     <= ST_RUN;
            out_q       <= 4'b0000;
            settle_q    <= 8'd0;
            proto_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= state_outputs(state_d);
            if (state_q == ST_SAVE) begin
                settle_q <= SETTLE_LOAD;
            end else if (state_q == ST_SETTLE && settle_q != 8'd0) begin
                settle_q <= settle_q - 8'd1;
            end else begin
                settle_q <= settle_q;
            end
            proto_err_q <= proto_err_q | cnt_err_s | (bus.biu_trans_req & hold_s);
        end
    end

    assign bus.corec_bus_hold      = hold_s;
    assign bus.corec_ret_save      = out_q.save;
    assign bus.corec_ret_restore   = out_q.restore;
    assign bus.corec_pmu_sleep_out = out_q.ack;
    assign bus.corec_pwr_sts       = state_q;
    assign bus.corec_proto_err     = proto_err_q;

endmodule
